approx_mac_acc: RTL and testbench
=================================

# approx_mac_acc

Streaming accumulator that sits directly downstream of the approximate 16x16 unsigned multipliers (the mul16u family). It consumes one 32-bit product per accepted beat, sums a vector of products terminated by a `last` flag with saturation, and presents the vector sum, term count and overflow flag on a held output until the consumer accepts it. This block turns a combinational approximate multiplier into a MAC datapath, so that error metrics and FPGA cost can be measured in a dot-product context.

## Interface
- `PROD_W`, default 32: product width from the multiplier.
- `ACC_W`, default 40: accumulator and result width. Must be ≥ `PROD_W`.
- `CNT_W`, default 16: width of the term counter.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_prod` in `PROD_W`: unsigned product (multiplier output `O`).
- `in_last` in 1: this beat ends the current vector.
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out `ACC_W`: saturated vector sum.
- `out_count` out `CNT_W`: number of beats in the vector, saturating.
- `out_ovf` out 1: the sum saturated at least once during the vector.

## Operation
- States:
  - `S_ACC`: accumulating. This is the reset state.
  - `S_HOLD`: a result is presented.
- Handshake and accept:
  - `in_ready = (state == S_ACC)`.
  - A beat is accepted when `in_valid && in_ready`.
- Accept without `in_last`, updates in the same cycle:
  - `acc <= sat(acc + zext(in_prod))`.
  - `cnt <= satinc(cnt)`.
  - `ovf <= ovf | carry`.
- Accept with `in_last`:
  - `out_sum`, `out_count` and `out_ovf` take the post-update values.
  - `acc`, `cnt` and `ovf` clear to 0.
  - State goes to `S_HOLD`.
- In `S_HOLD`:
  - `out_valid = 1` and all outputs stay stable.
  - On `out_ready`, go to `S_ACC`. `out_valid` falls next cycle.
- Saturation: when the true `ACC_W+1`-bit sum is ≥ 2^ACC_W, `acc = 2^ACC_W-1` and `ovf` is set.
- `cnt` saturates at 2^CNT_W-1. It does not wrap.
- `in_valid` low in `S_ACC`: nothing changes. An idle gap inside a vector is legal.
- A zero product still counts as a term.
- Reset in either state:
  - Discards any partial vector and any held result.
  - `acc`, `cnt`, `ovf`, `out_*` all go to 0.
  - State goes to `S_ACC`.

## Timing
- Reset values:
  - `in_ready = 1`, `out_valid = 0`.
  - `out_sum = 0`, `out_count = 0`, `out_ovf = 0`.
- Latency: `out_valid` rises the cycle after the `last` beat is accepted.
- Throughput:
  - One beat per cycle within a vector.
  - At least one cycle of `in_ready = 0` between vectors. This is the `S_HOLD` cycle; it lasts longer under backpressure.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- `out_*` are registered and change only on the `last` accept or on `rst`.
- Critical path: one `ACC_W`-bit add plus saturation mux. No pipelining inside the adder.

## Structure
- Package `approx_mac_pkg`:
  - State enum `{S_ACC, S_HOLD}`.
  - Default width constants `PROD_W`, `ACC_W`, `CNT_W`.
- Sub-module `mac_sat_add`:
  - Purely combinational.
  - Inputs: `a[ACC_W]` and `b[ACC_W]`.
  - Outputs: `sum[ACC_W]` and `sat`.
  - Instantiated once for the accumulator.
- The multiplier is not instantiated here. The top-level test harness connects multiplier `O` to `in_prod`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `in_valid = 1` → `in_ready = 1`, `out_valid = 0`, all outputs 0, nothing accumulated.
- **Basic vector:** beats `0x01000000`, `0x02000000`, `0x03000000` (last on the third), `out_ready = 1` → next cycle `out_sum = 0x0006000000`, `out_count = 3`, `out_ovf = 0`; `in_ready = 0` for exactly one cycle.
- **Saturation (`ACC_W = 33`):** three beats of `0xFF000000` → `out_sum = 0x1FFFFFFFF`, `out_count = 3`, `out_ovf = 1`; the next vector `{0x00000100 last}` gives `out_sum = 0x100`, `out_ovf = 0`.
- **Backpressure:** `out_ready = 0` for 5 cycles after result → `out_*` stable and `in_ready = 0` throughout; a presented `in_valid` beat is not consumed until the cycle after `out_ready = 1`.
- **Single-beat vector:** `{0xE1000000 last}` → `out_sum = 0xE1000000`, `out_count = 1`.
- **Reset mid-vector:**
  - Sequence: accept `0x05000000`, `0x05000000`, then pulse `rst`, then `{0x01000000 last}`.
  - Required: `out_sum = 0x01000000`, `out_count = 1`.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// approx_mac_pkg: shared state encoding and default widths for the approximate MAC accumulator
package approx_mac_pkg;
   localparam int PROD_W = 32;
   localparam int ACC_W  = 40;
   localparam int CNT_W  = 16;
   typedef enum logic {S_ACC, S_HOLD} state_t;
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: unsigned add that clamps to all-ones and flags the clamp
module mac_sat_add #(
   parameter int ACC_W = approx_mac_pkg::ACC_W
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);
   logic [ACC_W:0] full;
   // carry out of the full-width sum selects the saturated value
   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      sat  = full[ACC_W];
      sum  = sat ? '1 : full[ACC_W-1:0];
   end
endmodule

// File: rtl/approx_mac_acc.sv
// approx_mac_acc: saturating vector accumulator behind the approximate multipliers
module approx_mac_acc #(
   parameter int PROD_W = approx_mac_pkg::PROD_W,
   parameter int ACC_W  = approx_mac_pkg::ACC_W,
   parameter int CNT_W  = approx_mac_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);
   import approx_mac_pkg::*;
   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               ovf, ovf_nx, sat, accept;
   mac_sat_add #(.ACC_W(ACC_W)) u_add (
      .a  (acc),
      .b  (ACC_W'(in_prod)),
      .sum(acc_nx),
      .sat(sat)
   );
   // state register
   always_ff @(posedge clk)
      state <= rst ? S_ACC : state_nx;
   // hold a result after the last beat until the consumer takes it
   always_comb
      state_nx = state == S_ACC ? (accept && in_last ? S_HOLD : S_ACC)
                                : (out_ready ? S_ACC : S_HOLD);
   // handshake outputs and post-update running values
   always_comb begin
      in_ready  = state == S_ACC;
      out_valid = state == S_HOLD;
      accept    = in_valid && in_ready;
      cnt_nx    = &cnt ? cnt : cnt + CNT_W'(1);
      ovf_nx    = ovf | sat;
   end
   // running sums clear on the last beat, which also loads the held result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (accept) begin
         acc <= in_last ? '0 : acc_nx;
         cnt <= in_last ? '0 : cnt_nx;
         ovf <= in_last ? 1'b0 : ovf_nx;
         if (in_last) begin
            out_sum   <= acc_nx;
            out_count <= cnt_nx;
            out_ovf   <= ovf_nx;
         end
      end
   end
endmodule

// File: tb/tb_approx_mac_acc.sv
// tb_approx_mac_acc: directed and random vectors on a default and a narrow instance
module tb_approx_mac_acc;
   logic        clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
   logic [31:0] in_prod = '0;
   logic        ra, rb, va, vb, oa, ob;
   logic [39:0] sa;
   logic [32:0] sb;
   logic [15:0] ca;
   logic [2:0]  cb;
   int          n_tests = 0, n_fail = 0;
   logic [31:0] vec[$];

   always #5 clk = ~clk;

   approx_mac_acc dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ra), .in_prod(in_prod),
      .in_last(in_last), .out_valid(va), .out_ready(out_ready), .out_sum(sa),
      .out_count(ca), .out_ovf(oa)
   );

   approx_mac_acc #(.ACC_W(33), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rb), .in_prod(in_prod),
      .in_last(in_last), .out_valid(vb), .out_ready(out_ready), .out_sum(sb),
      .out_count(cb), .out_ovf(ob)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned total();
      longint unsigned t = 0;
      foreach (vec[i]) t += 64'(vec[i]);
      return t;
   endfunction

   function automatic logic [63:0] exp_sum(input int w);
      longint unsigned mx = (64'd1 << w) - 1;
      return total() > mx ? mx : total();
   endfunction

   function automatic logic [63:0] exp_ovf(input int w);
      return 64'(total() > ((64'd1 << w) - 1));
   endfunction

   function automatic logic [63:0] exp_cnt(input int w);
      longint unsigned mx = (64'd1 << w) - 1;
      longint unsigned n = 64'(vec.size());
      return n > mx ? mx : n;
   endfunction

   task automatic check_out(input string tag);
      chk({tag, "_sum_a"}, 64'(sa), exp_sum(40));
      chk({tag, "_sum_b"}, 64'(sb), exp_sum(33));
      chk({tag, "_cnt_a"}, 64'(ca), exp_cnt(16));
      chk({tag, "_cnt_b"}, 64'(cb), exp_cnt(3));
      chk({tag, "_ovf_a"}, 64'(oa), exp_ovf(40));
      chk({tag, "_ovf_b"}, 64'(ob), exp_ovf(33));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, 64'({ra, rb}), 64'd3);
      chk({tag, "_valid"}, 64'({va, vb}), 64'd0);
      chk({tag, "_outs"}, 64'({sa, sb, ca, cb, oa, ob} != '0), 64'd0);
   endtask

   // Feeds vec; with hold > 0 a last-flagged 0x11 beat stays presented through the
   // stall and the release, so the caller must follow with the vector {0x11}.
   task automatic run_vec(input int hold, input bit gaps);
      out_ready = hold == 0;
      foreach (vec[i]) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 0;
            step();
            chk("gap_ready", 64'({ra, rb}), 64'd3);
         end
         in_valid = 1;
         in_prod  = vec[i];
         in_last  = i == vec.size() - 1;
         step();
      end
      in_valid = 0;
      in_last  = 0;
      check_out("res");
      chk("res_valid", 64'({va, vb}), 64'd3);
      chk("res_ready", 64'({ra, rb}), 64'd0);
      repeat (hold) begin
         in_valid = 1;
         in_prod  = 32'h11;
         in_last  = 1;
         step();
         check_out("hold");
         chk("hold_valid", 64'({va, vb}), 64'd3);
         chk("hold_ready", 64'({ra, rb}), 64'd0);
      end
      out_ready = 1;
      step();
      check_out("rel");
      chk("rel_valid", 64'({va, vb}), 64'd0);
      chk("rel_ready", 64'({ra, rb}), 64'd3);
   endtask

   initial begin
      in_valid = 1;
      in_prod  = 32'h0F00_0000;
      in_last  = 0;
      repeat (3) begin
         step();
         check_idle("reset");
      end
      rst      = 0;
      in_valid = 0;
      step();
      check_idle("post_reset");

      vec = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
      run_vec(0, 0);
      chk("basic_sum", 64'(sa), 64'h0006000000);

      vec = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
      run_vec(0, 0);
      chk("sat_sum_b", 64'(sb), 64'h1FFFFFFFF);
      chk("sat_ovf_b", 64'(ob), 64'd1);
      vec = '{32'h0000_0100};
      run_vec(0, 0);
      chk("after_sat_ovf_b", 64'(ob), 64'd0);

      vec = '{32'h0000_0042, 32'h0000_0001};
      run_vec(5, 0);
      vec = '{32'h11};
      run_vec(0, 0);

      vec = '{32'hE100_0000};
      run_vec(0, 0);

      vec = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7};
      run_vec(0, 0);
      chk("cnt_sat_b", 64'(cb), 64'd7);

      in_valid = 1;
      in_prod  = 32'h0500_0000;
      in_last  = 0;
      step();
      step();
      in_valid = 0;
      rst      = 1;
      step();
      rst      = 0;
      check_idle("mid_rst");
      vec = '{32'h0100_0000};
      run_vec(0, 0);

      for (int v = 0; v < 25; v++) begin
         int len = $urandom_range(1, 10);
         int hold = $urandom_range(0, 3);
         vec = {};
         for (int i = 0; i < len; i++) vec.push_back($urandom);
         run_vec(hold, 1);
         if (hold > 0) begin
            vec = '{32'h11};
            run_vec(0, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
